aim65_kbd_injector: RTL



---
 rtl/aim65_kbd_injector.sv | 113 +++++++++++
 1 files changed

// File: rtl/aim65_kbd_injector.sv
// aim65_kbd_injector: merges live keys with a queued autotype source onto the AIM65 8x8 key matrix.
// Ports: clk/reset (sync, active-high); live_matrix[63:0] live keys (active-low, row r = bits 8r+7:8r);
// inj_valid/inj_code[6:0]/inj_ready code queue ({shift,row,col}); inj_flush drops queue and current key;
// csa4_riot6532_paOut[7:0] row scan in, csa4_riot6532_pbIn[7:0] registered column result out;
// busy (sequencing or queued), owner (injector asserting any matrix bit).
// Optional: define AIM65_KBD_LIVE_ABORT_EN so a live key pressed mid-sequence aborts injection.
module aim65_kbd_injector #(
  parameter int HOLD_CYCLES = 200000,
  parameter int GAP_CYCLES  = 200000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] live_matrix,
  input  logic        inj_valid,
  input  logic [6:0]  inj_code,
  output logic        inj_ready,
  input  logic        inj_flush,
  input  logic [7:0]  csa4_riot6532_paOut,
  output logic [7:0]  csa4_riot6532_pbIn,
  output logic        busy,
  output logic        owner
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] HOLD_LD = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LD = 32'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SHIFT_SETUP, PRESS, RELEASE, GAP} state_t;
  state_t state, state_n;
  logic [31:0] timer, timer_n;
  logic [6:0] mem [FIFO_DEPTH];
  logic [6:0] cur, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic live_idle, flush, push, pop, done, key_on, shift_on;
  logic [63:0] asserted, merged;
  logic [7:0] scan;
  assign live_idle = &live_matrix;
`ifdef AIM65_KBD_LIVE_ABORT_EN
  assign flush = inj_flush | (state != IDLE && !live_idle);
`else
  assign flush = inj_flush;
`endif
  assign head = mem[rd_ptr];
  assign inj_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push = inj_valid & inj_ready & ~flush;
  assign pop = state == IDLE && count != '0 && live_idle && !flush;
  assign done = timer == '0;
  always_comb begin
    state_n = state;
    timer_n = done ? timer : timer - 32'd1;
    case (state)
      IDLE: if (pop) begin
        state_n = head[6] ? SHIFT_SETUP : PRESS;
        timer_n = head[6] ? GAP_LD : HOLD_LD;
      end
      SHIFT_SETUP: if (done) begin
        state_n = PRESS;
        timer_n = HOLD_LD;
      end
      PRESS: if (done) begin
        state_n = cur[6] ? RELEASE : GAP;
        timer_n = GAP_LD;
      end
      RELEASE: if (done) begin
        state_n = GAP;
        timer_n = GAP_LD;
      end
      GAP: if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush && state != IDLE) begin
      state_n = GAP;
      timer_n = GAP_LD;
    end
  end
  // Shift lives at PA6/PB0; a code's bit index is {row,col} = row*8+col.
  assign key_on = state == PRESS;
  assign shift_on = state == SHIFT_SETUP || state == RELEASE || (key_on && cur[6]);
  assign asserted = ({63'd0, key_on} << cur[5:0]) | ({63'd0, shift_on} << 48);
  assign merged = live_matrix & ~asserted;
  assign owner = |asserted;
  assign busy = state != IDLE || count != '0;
  always_comb begin
    scan = 8'hFF;
    for (int r = 0; r < 8; r++) scan &= csa4_riot6532_paOut[r] ? 8'hFF : merged[8*r +: 8];
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= inj_code;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      cur <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      csa4_riot6532_pbIn <= 8'hFF;
    end else begin
      state <= state_n;
      timer <= timer_n;
      csa4_riot6532_pbIn <= scan;
      if (pop) cur <= head;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule
